fetch_pc_unit: RTL and testbench

Program-counter register and instruction-fetch sequencer for the vector processor front end. It holds the 16-bit PC, fetches one instruction word per request from instruction memory over a req/ack handshake, and presents the fetched word to decode over a valid/ready handshake. All next-PC arithmetic is performed by the existing `pcadder` stage: this block drives its `A`/`B` operands and consumes its combinational sum `C`.

---
 rtl/fetch_pc_unit.sv | 115 +++++++++++
 tb/tb_fetch_pc_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// Program counter and instruction-fetch sequencer for the vector front end.
// Next-PC sums come from the external pcadder via Add_A/Add_B -> Add_C.
module fetch_pc_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] INSTR_INC = 16'd1
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Enable,
    output logic        Mem_Req,
    output logic [15:0] Mem_Addr,
    input  logic        Mem_Ack,
    input  logic [15:0] Mem_Data,
    output logic [15:0] Add_A,
    output logic [15:0] Add_B,
    input  logic [15:0] Add_C,
    input  logic        Br_Taken,
    input  logic [15:0] Br_Base,
    input  logic [15:0] Br_Offset,
    output logic [15:0] IR,
    output logic [15:0] IR_PC,
    output logic        IR_Valid,
    input  logic        IR_Ready,
    output logic [15:0] PC
);

    typedef enum logic [1:0] {
        HALT    = 2'd0,
        FETCH   = 2'd1,
        DELIVER = 2'd2
    } state_t;

    state_t      state, state_nx, resume;
    logic [15:0] pc, pc_nx;
    logic [15:0] ir, ir_nx;
    logic [15:0] ir_pc, ir_pc_nx;
    logic [15:0] pend_tgt, pend_tgt_nx;
    logic        pend, pend_nx;

    assign Add_A    = Br_Taken ? Br_Base   : pc;
    assign Add_B    = Br_Taken ? Br_Offset : INSTR_INC;
    assign Mem_Req  = (state == FETCH);
    assign Mem_Addr = pc;
    assign IR_Valid = (state == DELIVER);
    assign IR       = ir;
    assign IR_PC    = ir_pc;
    assign PC       = pc;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state    <= HALT;
            pc       <= RESET_PC;
            ir       <= 16'h0000;
            ir_pc    <= 16'h0000;
            pend     <= 1'b0;
            pend_tgt <= 16'h0000;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            ir       <= ir_nx;
            ir_pc    <= ir_pc_nx;
            pend     <= pend_nx;
            pend_tgt <= pend_tgt_nx;
        end
    end

    // A redirect seen while a request is outstanding is parked in pend_tgt,
    // since the memory request cannot be withdrawn before its ack.
    always_comb begin
        state_nx    = state;
        pc_nx       = pc;
        ir_nx       = ir;
        ir_pc_nx    = ir_pc;
        pend_nx     = pend;
        pend_tgt_nx = pend_tgt;
        resume      = Enable ? FETCH : HALT;

        case (state)
            HALT: begin
                if (Br_Taken) pc_nx = Add_C;
                if (Enable) state_nx = FETCH;
            end
            FETCH: begin
                if (Mem_Ack) begin
                    pend_nx = 1'b0;
                    if (Br_Taken) begin
                        pc_nx    = Add_C;
                        state_nx = resume;
                    end else if (pend) begin
                        pc_nx    = pend_tgt;
                        state_nx = resume;
                    end else begin
                        ir_nx    = Mem_Data;
                        ir_pc_nx = pc;
                        pc_nx    = Add_C;
                        state_nx = DELIVER;
                    end
                end else if (Br_Taken) begin
                    pend_nx     = 1'b1;
                    pend_tgt_nx = Add_C;
                end
            end
            DELIVER: begin
                if (Br_Taken) begin
                    pc_nx    = Add_C;
                    state_nx = resume;
                end else if (IR_Ready) begin
                    state_nx = resume;
                end
            end
            default: state_nx = HALT;
        endcase
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed vector table, wrap/async-reset sequence on a
// second instance, then random traffic against a behavioural model.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        reset, reset2;
    logic        enable, mem_ack, ir_ready, br_taken;
    logic [15:0] mem_data, br_base, br_offset;

    logic        mem_req, ir_valid;
    logic [15:0] mem_addr, add_a, add_b, add_c, ir, ir_pc, pc;
    logic        mem_req2, ir_valid2;
    logic [15:0] mem_addr2, add_a2, add_b2, add_c2, ir2, ir_pc2, pc2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // pcadder stand-ins
    assign add_c  = add_a + add_b;
    assign add_c2 = add_a2 + add_b2;

    fetch_pc_unit dut (
        .CLK(clk), .Reset(reset), .Enable(enable),
        .Mem_Req(mem_req), .Mem_Addr(mem_addr), .Mem_Ack(mem_ack), .Mem_Data(mem_data),
        .Add_A(add_a), .Add_B(add_b), .Add_C(add_c),
        .Br_Taken(br_taken), .Br_Base(br_base), .Br_Offset(br_offset),
        .IR(ir), .IR_PC(ir_pc), .IR_Valid(ir_valid), .IR_Ready(ir_ready), .PC(pc)
    );

    fetch_pc_unit #(.RESET_PC(16'hFFFF), .INSTR_INC(16'd1)) dut2 (
        .CLK(clk), .Reset(reset2), .Enable(enable),
        .Mem_Req(mem_req2), .Mem_Addr(mem_addr2), .Mem_Ack(mem_ack), .Mem_Data(mem_data),
        .Add_A(add_a2), .Add_B(add_b2), .Add_C(add_c2),
        .Br_Taken(br_taken), .Br_Base(br_base), .Br_Offset(br_offset),
        .IR(ir2), .IR_PC(ir_pc2), .IR_Valid(ir_valid2), .IR_Ready(ir_ready), .PC(pc2)
    );

    typedef struct {
        bit          en, ack, rdy, br;
        logic [15:0] base, off, data;
        bit          req;
        logic [15:0] addr;
        bit          valid;
        logic [15:0] ir, irpc, pc;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model: "fetching"/"holding" flags plus a queue of at most one parked target
    bit          m_fetching, m_holding;
    logic [15:0] m_pc, m_ir, m_irpc;
    logic [15:0] m_pend[$];

    task automatic add_vec(input bit en, ack, rdy, br, input logic [15:0] base, off, data,
                           input bit req, input logic [15:0] addr, input bit valid,
                           input logic [15:0] e_ir, e_irpc, e_pc);
        vec_t v;
        v.en = en; v.ack = ack; v.rdy = rdy; v.br = br;
        v.base = base; v.off = off; v.data = data;
        v.req = req; v.addr = addr; v.valid = valid;
        v.ir = e_ir; v.irpc = e_irpc; v.pc = e_pc;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input bit en, ack, rdy, br, input logic [15:0] base, off, data);
        enable = en; mem_ack = ack; ir_ready = rdy; br_taken = br;
        br_base = base; br_offset = off; mem_data = data;
    endtask

    task automatic check_output(input string tag, input bit req, input logic [15:0] addr,
                                input bit valid, input logic [15:0] e_ir, e_irpc, e_pc);
        check({tag, ".req"},   {15'd0, mem_req},  {15'd0, req});
        check({tag, ".addr"},  mem_addr, addr);
        check({tag, ".valid"}, {15'd0, ir_valid}, {15'd0, valid});
        check({tag, ".ir"},    ir, e_ir);
        check({tag, ".irpc"},  ir_pc, e_irpc);
        check({tag, ".pc"},    pc, e_pc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_fetching = 0; m_holding = 0;
        m_pc = 16'h0000; m_ir = 16'h0000; m_irpc = 16'h0000;
        m_pend.delete();
    endtask

    task automatic model_step(input bit en, ack, rdy, br, input logic [15:0] base, off, data);
        logic [15:0] tgt;
        tgt = base + off;
        if (m_holding) begin
            if (br) m_pc = tgt;
            if (br || rdy) begin
                m_holding  = 0;
                m_fetching = en;
            end
        end else if (m_fetching) begin
            if (ack) begin
                if (br) m_pc = tgt;
                else if (m_pend.size() > 0) m_pc = m_pend[0];
                else begin
                    m_ir = data; m_irpc = m_pc; m_pc = m_pc + 16'd1;
                    m_holding = 1;
                end
                m_fetching = m_holding ? 1'b0 : en;
                m_pend.delete();
            end else if (br) begin
                m_pend.delete();
                m_pend.push_back(tgt);
            end
        end else begin
            if (br) m_pc = tgt;
            m_fetching = en;
        end
    endtask

    initial begin
        // en ack rdy br base off data | req addr valid ir irpc pc
        add_vec(1,0,0,0,16'h0000,16'h0000,16'h0000, 1,16'h0000,0,16'h0000,16'h0000,16'h0000);
        add_vec(1,1,0,0,16'h0000,16'h0000,16'hA000, 0,16'h0001,1,16'hA000,16'h0000,16'h0001);
        add_vec(1,0,1,0,16'h0000,16'h0000,16'h0000, 1,16'h0001,0,16'hA000,16'h0000,16'h0001);
        add_vec(1,1,0,0,16'h0000,16'h0000,16'hA001, 0,16'h0002,1,16'hA001,16'h0001,16'h0002);
        add_vec(1,0,1,0,16'h0000,16'h0000,16'h0000, 1,16'h0002,0,16'hA001,16'h0001,16'h0002);
        for (int i = 0; i < 3; i++)
            add_vec(1,0,0,0,16'h0000,16'h0000,16'h0000, 1,16'h0002,0,16'hA001,16'h0001,16'h0002);
        add_vec(1,1,0,0,16'h0000,16'h0000,16'hA002, 0,16'h0003,1,16'hA002,16'h0002,16'h0003);
        for (int i = 0; i < 5; i++)
            add_vec(1,0,0,0,16'h0000,16'h0000,16'h0000, 0,16'h0003,1,16'hA002,16'h0002,16'h0003);
        add_vec(1,0,1,0,16'h0000,16'h0000,16'h0000, 1,16'h0003,0,16'hA002,16'h0002,16'h0003);
        add_vec(1,1,0,0,16'h0000,16'h0000,16'hA003, 0,16'h0004,1,16'hA003,16'h0003,16'h0004);
        add_vec(1,0,1,0,16'h0000,16'h0000,16'h0000, 1,16'h0004,0,16'hA003,16'h0003,16'h0004);
        add_vec(1,1,0,0,16'h0000,16'h0000,16'hA004, 0,16'h0005,1,16'hA004,16'h0004,16'h0005);
        add_vec(1,0,0,1,16'h0004,16'hFFFE,16'h0000, 1,16'h0002,0,16'hA004,16'h0004,16'h0002);
        add_vec(1,0,0,1,16'h0040,16'h0000,16'h0000, 1,16'h0002,0,16'hA004,16'h0004,16'h0002);
        add_vec(1,0,0,0,16'h0000,16'h0000,16'h0000, 1,16'h0002,0,16'hA004,16'h0004,16'h0002);
        add_vec(1,1,0,0,16'h0000,16'h0000,16'hBEEF, 1,16'h0040,0,16'hA004,16'h0004,16'h0040);
        add_vec(0,0,0,0,16'h0000,16'h0000,16'h0000, 1,16'h0040,0,16'hA004,16'h0004,16'h0040);
        add_vec(0,1,0,0,16'h0000,16'h0000,16'hC000, 0,16'h0041,1,16'hC000,16'h0040,16'h0041);
        add_vec(0,0,1,0,16'h0000,16'h0000,16'h0000, 0,16'h0041,0,16'hC000,16'h0040,16'h0041);
        add_vec(0,0,0,0,16'h0000,16'h0000,16'h0000, 0,16'h0041,0,16'hC000,16'h0040,16'h0041);
        add_vec(1,0,0,0,16'h0000,16'h0000,16'h0000, 1,16'h0041,0,16'hC000,16'h0040,16'h0041);
        add_vec(1,1,0,1,16'h0100,16'h0020,16'hDEAD, 1,16'h0120,0,16'hC000,16'h0040,16'h0120);
        add_vec(0,1,0,0,16'h0000,16'h0000,16'h1234, 0,16'h0121,1,16'h1234,16'h0120,16'h0121);
        add_vec(0,0,1,1,16'hFFFF,16'h0001,16'h0000, 0,16'h0000,0,16'h1234,16'h0120,16'h0000);
        add_vec(1,0,0,0,16'h0000,16'h0000,16'h0000, 1,16'h0000,0,16'h1234,16'h0120,16'h0000);
        add_vec(1,0,0,1,16'h0010,16'h0000,16'h0000, 1,16'h0000,0,16'h1234,16'h0120,16'h0000);
        add_vec(1,1,0,1,16'h0020,16'h0000,16'h9999, 1,16'h0020,0,16'h1234,16'h0120,16'h0020);
        add_vec(1,1,0,0,16'h0000,16'h0000,16'h5555, 0,16'h0021,1,16'h5555,16'h0020,16'h0021);
        add_vec(1,0,0,1,16'h0030,16'h0000,16'h0000, 1,16'h0030,0,16'h5555,16'h0020,16'h0030);
        add_vec(0,0,0,1,16'h0050,16'h0000,16'h0000, 1,16'h0030,0,16'h5555,16'h0020,16'h0030);
        add_vec(0,1,0,0,16'h0000,16'h0000,16'h1111, 0,16'h0050,0,16'h5555,16'h0020,16'h0050);
        add_vec(0,0,0,1,16'h0060,16'h0000,16'h0000, 0,16'h0060,0,16'h5555,16'h0020,16'h0060);

        apply_stimulus(0,0,0,0,16'h0,16'h0,16'h0);
        reset = 1'b1; reset2 = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_output("reset", 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000);

        $display("[TB] directed vector table, %0d rows", vecs.size());
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].en, vecs[i].ack, vecs[i].rdy, vecs[i].br,
                           vecs[i].base, vecs[i].off, vecs[i].data);
            step();
            check_output($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].valid,
                         vecs[i].ir, vecs[i].irpc, vecs[i].pc);
        end

        $display("[TB] RESET_PC=FFFF wrap and asynchronous reset");
        apply_stimulus(0,0,0,0,16'h0,16'h0,16'h0);
        reset2 = 1'b0;
        check("wrap.pc_reset", pc2, 16'hFFFF);
        apply_stimulus(1,0,0,0,16'h0,16'h0,16'h0);
        step();
        check("wrap.req", {15'd0, mem_req2}, 16'd1);
        check("wrap.addr", mem_addr2, 16'hFFFF);
        apply_stimulus(1,1,0,0,16'h0,16'h0,16'h7777);
        step();
        check("wrap.ir", ir2, 16'h7777);
        check("wrap.irpc", ir_pc2, 16'hFFFF);
        check("wrap.pc", pc2, 16'h0000);
        check("wrap.valid", {15'd0, ir_valid2}, 16'd1);
        apply_stimulus(1,0,1,0,16'h0,16'h0,16'h0);
        step();
        check("wrap.addr2", mem_addr2, 16'h0000);
        apply_stimulus(1,0,0,0,16'h0,16'h0,16'h0);
        step();
        check("wrap.req2", {15'd0, mem_req2}, 16'd1);
        #1 reset2 = 1'b1;
        #1;
        check("areset.req", {15'd0, mem_req2}, 16'd0);
        check("areset.pc", pc2, 16'hFFFF);
        check("areset.valid", {15'd0, ir_valid2}, 16'd0);
        check("areset.ir", ir2, 16'h0000);
        check("areset.irpc", ir_pc2, 16'h0000);
        step();

        $display("[TB] random traffic against model");
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        model_reset();
        check_output("rreset", 0, m_pc, 0, m_ir, m_irpc, m_pc);
        for (int n = 0; n < 400; n++) begin
            bit          en, ack, rdy, br;
            logic [15:0] base, off, data;
            en   = ($urandom_range(0, 9) != 0);
            ack  = $urandom_range(0, 1) == 1;
            rdy  = $urandom_range(0, 1) == 1;
            br   = ($urandom_range(0, 6) == 0);
            base = 16'($urandom);
            off  = 16'($urandom);
            data = 16'($urandom);
            apply_stimulus(en, ack, rdy, br, base, off, data);
            model_step(en, ack, rdy, br, base, off, data);
            step();
            check_output($sformatf("rnd%0d", n), m_fetching, m_pc, m_holding, m_ir, m_irpc, m_pc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
